// File: rtl/dcache_pkg.sv
// dcache_pkg: shared constants and enums for the direct-mapped write-back
// data cache. Geometry is fixed here and used by every cache file.
package dcache_pkg;

    localparam int NUM_LINES      = 8;
    localparam int WORDS_PER_LINE = 4;
    localparam int IDX_W          = $clog2(NUM_LINES);
    localparam int OFF_W          = 2;
    localparam int TAG_W          = 30 - IDX_W - OFF_W;
    localparam int LINE_W         = 32 * WORDS_PER_LINE;

    typedef enum logic [1:0] {
        COMPARE   = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    // Line array write-port modes
    typedef enum logic [1:0] {
        WR_NONE  = 2'd0,
        WR_WORD  = 2'd1,   // merge one word, mark dirty
        WR_FILL  = 2'd2,   // load whole line + tag, valid=1, dirty=0
        WR_CLEAN = 2'd3    // clear dirty after a writeback
    } wr_mode_t;

endpackage

// File: rtl/dcache_line_array.sv
// dcache_line_array: tag/valid/dirty/data storage for the cache.
// Ports:
//   clk, rst             clock, async active-high reset (valid/dirty only)
//   rd_idx               combinational read index
//   rd_valid/rd_dirty    status of the indexed line
//   rd_tag/rd_line       tag and 128-bit data of the indexed line
//   wr_mode              write-port operation (none/word/fill/clean)
//   wr_idx/wr_off        line index and word offset for the write port
//   wr_word              word merged in WR_WORD mode
//   wr_tag/wr_line       tag and line loaded in WR_FILL mode
module dcache_line_array
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line,
    input  wr_mode_t          wr_mode,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [31:0]       wr_word,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_line
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            case (wr_mode)
                WR_WORD:  dirty_q[wr_idx] <= 1'b1;
                WR_FILL: begin
                    valid_q[wr_idx] <= 1'b1;
                    dirty_q[wr_idx] <= 1'b0;
                end
                WR_CLEAN: dirty_q[wr_idx] <= 1'b0;
                default: ;
            endcase
        end
    end

    // Tag and data are not reset; valid=0 masks their contents.
    always_ff @(posedge clk) begin
        case (wr_mode)
            WR_WORD: data_q[wr_idx][{wr_off, 5'd0} +: 32] <= wr_word;
            WR_FILL: begin
                data_q[wr_idx] <= wr_line;
                tag_q[wr_idx]  <= wr_tag;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dcache_dm_wb.sv
// dcache_dm_wb: direct-mapped, write-back, write-allocate data cache.
// Ports:
//   clk, proc_reset        clock, async active-high reset
//   proc_read/proc_write   core request (write wins if both set)
//   proc_addr/proc_wdata   30-bit word address, write word
//   proc_stall/proc_rdata  combinational stall and read word
//   mem_read/mem_write     registered refill / writeback requests
//   mem_addr/mem_wdata     block address and victim line (0 when idle)
//   mem_rdata/mem_ready    refill line and one-cycle completion pulse
//
// state     | meaning
// ----------+--------------------------------------------------------
// COMPARE   | lookup; hits complete with zero stall, misses leave
// WRITEBACK | dirty victim being written to memory
// ALLOCATE  | requested line being refilled from memory
module dcache_dm_wb
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              proc_read,
    input  logic              proc_write,
    input  logic [29:0]       proc_addr,
    input  logic [31:0]       proc_wdata,
    output logic              proc_stall,
    output logic [31:0]       proc_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [27:0]       mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_t            state;
    wr_mode_t          wr_mode;

    logic [OFF_W-1:0]  addr_off;
    logic [IDX_W-1:0]  addr_idx;
    logic [TAG_W-1:0]  addr_tag;
    logic              req;
    logic              hit;
    logic              line_valid;
    logic              line_dirty;
    logic [TAG_W-1:0]  line_tag;
    logic [LINE_W-1:0] line_data;
    logic [31:0]       line_word;

    assign addr_off  = proc_addr[OFF_W-1:0];
    assign addr_idx  = proc_addr[OFF_W +: IDX_W];
    assign addr_tag  = proc_addr[OFF_W+IDX_W +: TAG_W];
    assign req       = proc_read | proc_write;
    assign hit       = line_valid && (line_tag == addr_tag);
    assign line_word = line_data[{addr_off, 5'd0} +: 32];

    dcache_line_array u_lines (
        .clk      (clk),
        .rst      (proc_reset),
        .rd_idx   (addr_idx),
        .rd_valid (line_valid),
        .rd_dirty (line_dirty),
        .rd_tag   (line_tag),
        .rd_line  (line_data),
        .wr_mode  (wr_mode),
        .wr_idx   (addr_idx),
        .wr_off   (addr_off),
        .wr_word  (proc_wdata),
        .wr_tag   (addr_tag),
        .wr_line  (mem_rdata)
    );

    always_comb begin
        wr_mode = WR_NONE;
        case (state)
            COMPARE:   if (proc_write && hit) wr_mode = WR_WORD;
            WRITEBACK: if (mem_ready)         wr_mode = WR_CLEAN;
            ALLOCATE:  if (mem_ready)         wr_mode = WR_FILL;
            default:   wr_mode = WR_NONE;
        endcase
    end

    assign proc_stall = (state != COMPARE) || (req && !hit);

    // A simultaneous read+write is a write, so it returns no data.
    assign proc_rdata = (state == COMPARE && proc_read && !proc_write && hit)
                        ? line_word : 32'd0;

    // Memory-side outputs are loaded on the transition into each memory
    // state, so they stay stable for the whole request and drop with it.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state     <= COMPARE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                COMPARE: begin
                    if (req && !hit) begin
                        if (line_valid && line_dirty) begin
                            state     <= WRITEBACK;
                            mem_write <= 1'b1;
                            mem_addr  <= {line_tag, addr_idx};
                            mem_wdata <= line_data;
                        end else begin
                            state    <= ALLOCATE;
                            mem_read <= 1'b1;
                            mem_addr <= proc_addr[29:2];
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        state     <= ALLOCATE;
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                        mem_addr  <= proc_addr[29:2];
                        mem_wdata <= '0;
                    end
                end
                ALLOCATE: begin
                    if (mem_ready) begin
                        state    <= COMPARE;
                        mem_read <= 1'b0;
                        mem_addr <= '0;
                    end
                end
                default: begin
                    state     <= COMPARE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                end
            endcase
        end
    end

endmodule
